// File: rtl/and_unit_pkg.sv
// ============================================================================
// Module      : and_unit_pkg
// Description : Shared width constant and result word type for the AND unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package and_unit_pkg;

    localparam int AND_WIDTH = 20;

    typedef logic [AND_WIDTH-1:0] and_word_t;

    function automatic logic is_all_zero(input and_word_t v);
        return (v == '0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/and_unit_core.sv
// ============================================================================
// Module      : and_unit_core
// Description : Purely combinational bitwise AND of two operands.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module and_unit_core
    import and_unit_pkg::*;
#(
    parameter int WIDTH = AND_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    assign y = a & b;

endmodule

`default_nettype wire

// File: rtl/and_unit.sv
// ============================================================================
// Module      : and_unit
// Description : Valid/ready wrapped bitwise AND with a one-slot output
//               register and one-cycle latency. Macro AND_UNIT_ZERO_FLAG_EN
//               enables the registered all-zeros flag; otherwise zero is 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module and_unit
    import and_unit_pkg::*;
#(
    parameter int WIDTH = AND_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] c,
    output logic             zero,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] w_y;
    logic             w_in_xfer;
    logic [WIDTH-1:0] r_c;
    logic             r_out_valid;

    and_unit_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a (a),
        .b (b),
        .y (w_y)
    );

    // The slot may be refilled in the same cycle it is drained.
    assign in_ready  = ~r_out_valid | out_ready;
    assign w_in_xfer = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c         <= '0;
            r_out_valid <= 1'b0;
        end else if (w_in_xfer) begin
            r_c         <= w_y;
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign c         = r_c;
    assign out_valid = r_out_valid;

`ifdef AND_UNIT_ZERO_FLAG_EN
    logic r_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zero <= 1'b0;
        end else if (w_in_xfer) begin
            r_zero <= (w_y == '0);
        end
    end

    assign zero = r_zero;
`else
    assign zero = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_and_unit.sv
// ============================================================================
// Module      : tb_and_unit
// Description : Self-checking bench for and_unit: directed cases plus random
//               traffic against a queue-based result model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_and_unit;

    localparam int W = 20;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] c;
    logic         zero;
    logic         out_valid;
    logic         out_ready;

    int n_checks;
    int n_errors;

    // Model: results accepted but not yet consumed, plus the last result
    // loaded into the output register (held after being consumed).
    logic [W-1:0] q_pend[$];
    logic [W-1:0] m_last_c;

    and_unit #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .c         (c),
        .zero      (zero),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_zero(input logic [W-1:0] v);
`ifdef AND_UNIT_ZERO_FLAG_EN
        return (v == '0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(q_pend.size() != 0));
        check({tag, ".c"},         32'(c),         32'(m_last_c));
        check({tag, ".zero"},      32'(zero),      32'(exp_zero(m_last_c)));
    endtask

    // One clock cycle: drive, check in_ready, clock, update model, check outputs.
    task automatic cycle(input string tag, input logic iv, input logic [W-1:0] av,
                         input logic [W-1:0] bv, input logic orr);
        bit exp_rdy, in_x, out_x;
        in_valid  = iv;
        a         = av;
        b         = bv;
        out_ready = orr;
        #1;
        exp_rdy = (q_pend.size() == 0) || orr;
        check({tag, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
        in_x  = iv && exp_rdy;
        out_x = (q_pend.size() != 0) && orr;
        @(posedge clk);
        if (out_x) void'(q_pend.pop_front());
        if (in_x) begin
            q_pend.push_back(av & bv);
            m_last_c = av & bv;
        end
        #1;
        check_outputs(tag);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        m_last_c  = '0;
        rst_n     = 1'b0;
        a         = '0;
        b         = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        #2;
        check_outputs("reset_async");
        @(posedge clk);
        #1;
        check_outputs("reset_held");
        rst_n = 1'b1;
        #1;
        check("post_reset.in_ready", 32'(in_ready), 32'd1);

        // Directed cases
        cycle("a0b0", 1'b1, 20'h00000, 20'h00000, 1'b1);
        cycle("a0b1", 1'b1, 20'h00000, 20'h00001, 1'b1);
        cycle("a1b0", 1'b1, 20'h00001, 20'h00000, 1'b1);
        cycle("a1b1", 1'b1, 20'h00001, 20'h00001, 1'b1);
        check("a1b1.c_lit", 32'(c), 32'h00001);
        cycle("btb1", 1'b1, 20'hFFFFF, 20'hAAAAA, 1'b1);
        check("btb1.c_lit", 32'(c), 32'hAAAAA);
        cycle("btb2", 1'b1, 20'h55555, 20'hAAAAA, 1'b1);
        check("btb2.c_lit", 32'(c), 32'h00000);
        check("btb2.valid_lit", 32'(out_valid), 32'd1);
        cycle("drain", 1'b0, 20'h0, 20'h0, 1'b1);

        // Backpressure: pending result holds while consumer stalls
        cycle("bp_load",  1'b1, 20'h0F0F0, 20'hFFFFF, 1'b0);
        cycle("bp_stall1", 1'b1, 20'h12345, 20'hFFFFF, 1'b0);
        cycle("bp_stall2", 1'b1, 20'h12345, 20'hFFFFF, 1'b0);
        check("bp.c_lit", 32'(c), 32'h0F0F0);
        cycle("bp_release", 1'b1, 20'h12345, 20'hFFFFF, 1'b1);
        check("bp_release.c_lit", 32'(c), 32'h12345);

        // Asynchronous reset mid-stream with a result pending
        cycle("pre_rst", 1'b1, 20'hABCDE, 20'hFFFFF, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        q_pend.delete();
        m_last_c = '0;
        check_outputs("mid_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle("after_rst", 1'b1, 20'h00003, 20'h00007, 1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle("rand", 1'($urandom_range(0, 3) != 0),
                  W'($urandom), W'(($urandom_range(0, 7) == 0) ? 0 : $urandom),
                  1'($urandom_range(0, 2) != 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
